// File: rtl/demosaic_window.sv
// Streaming Bayer demosaic over a 2x2 window (A B / C D).
// A one-line buffer supplies the row above, registers hold the left
// neighbours, and each accepted sample D=(x,y) yields RGB two edges later
// when the output mode selects that position.
module demosaic_window #(
  parameter int WIDTH   = 320,
  parameter int HEIGHT  = 240,
  parameter int DATA_W  = 8,
  parameter int PATTERN = 0,
  parameter int MODE    = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] iData,
  input  logic              iValid,
  input  logic              iSof,
  output logic [DATA_W-1:0] oR,
  output logic [DATA_W-1:0] oG,
  output logic [DATA_W-1:0] oB,
  output logic              oValid,
  output logic              oSof,
  output logic              oEof
);

  localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  localparam logic [XW-1:0] X_LAST   = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(HEIGHT - 1);
  localparam logic [1:0]    PAT_BITS = 2'(PATTERN);

  // Colour of D in RGGB terms after folding in the CFA phase:
  // bit 1 = odd row (blue row), bit 0 = odd column.
  typedef enum logic [1:0] {
    PH_R  = 2'b00,
    PH_GR = 2'b01,
    PH_GB = 2'b10,
    PH_B  = 2'b11
  } phase_e;

  // Truncating average with one guard bit so the carry is not lost.
  function automatic logic [DATA_W-1:0] avg(input logic [DATA_W-1:0] p,
                                            input logic [DATA_W-1:0] q);
    logic [DATA_W:0] sum;
    sum = {1'b0, p} + {1'b0, q};
    return sum[DATA_W:1];
  endfunction

  // ---------------------------------------------------------------------
  // Input stage: position tracking
  // ---------------------------------------------------------------------
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic [XW-1:0] cur_x;
  logic [YW-1:0] cur_y;
  logic [XW-1:0] nxt_x;
  logic [YW-1:0] nxt_y;
  logic          accept;
  logic          emit;
  logic          at_first;
  logic          at_last;
  phase_e        cur_phase;

  // Reset blocks acceptance so nothing reaches the line buffer or pipeline.
  assign accept = iValid && reset;

  // Position of the current sample (iSof resyncs it to the origin) and
  // the position the next sample will take.
  // NOTE: every signal driven here gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    cur_x = x_q;
    cur_y = y_q;
    if (iSof) begin
      cur_x = '0;
      cur_y = '0;
    end
    nxt_x = cur_x + XW'(1);
    nxt_y = cur_y;
    if (cur_x == X_LAST) begin
      nxt_x = '0;
      nxt_y = (cur_y == Y_LAST) ? '0 : cur_y + YW'(1);
    end
  end

  // Which positions produce an output, and the frame markers.
  always_comb begin
    emit = 1'b0;
    if (MODE == 0) begin
      emit = cur_x[0] && cur_y[0];
    end else begin
      emit = (cur_x != '0) && (cur_y != '0);
    end
    at_first  = (cur_x == XW'(1)) && (cur_y == YW'(1));
    at_last   = (cur_x == X_LAST) && (cur_y == Y_LAST);
    cur_phase = phase_e'({cur_y[0] ^ PAT_BITS[1], cur_x[0] ^ PAT_BITS[0]});
  end

  // Raster counters advance only on accepted samples.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      x_q <= '0;
      y_q <= '0;
    end else if (accept) begin
      x_q <= nxt_x;
      y_q <= nxt_y;
    end
  end

  // ---------------------------------------------------------------------
  // Line buffer: read-before-write at the same column gives B=(x,y-1)
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] line_mem [WIDTH];
  logic [DATA_W-1:0] above_q;

  // Line buffer write and synchronous read on each accept.
  // NOTE: the RAM and its read register are deliberately not reset; row 0
  // never emits, so stale contents are overwritten before they matter.
  always_ff @(posedge clk) begin
    if (accept) begin
      above_q         <= line_mem[cur_x];
      line_mem[cur_x] <= iData;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 1: window registers (A, C, D) and control flags
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] d_q;
  logic [DATA_W-1:0] c_q;
  logic [DATA_W-1:0] a_q;
  phase_e            s1_phase;
  logic              s1_valid;
  logic              s1_sof;
  logic              s1_eof;

  // Left neighbours shift on accept; the flags advance every cycle so
  // input gaps become output gaps.
  always_ff @(posedge clk) begin
    if (!reset) begin
      d_q      <= '0;
      c_q      <= '0;
      a_q      <= '0;
      s1_phase <= PH_R;
      s1_valid <= 1'b0;
      s1_sof   <= 1'b0;
      s1_eof   <= 1'b0;
    end else begin
      if (accept) begin
        d_q      <= iData;
        c_q      <= d_q;
        a_q      <= above_q;
        s1_phase <= cur_phase;
      end
      s1_valid <= accept && emit;
      s1_sof   <= accept && emit && at_first;
      s1_eof   <= accept && emit && at_last;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: channel assignment from the window
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] win_r;
  logic [DATA_W-1:0] win_g;
  logic [DATA_W-1:0] win_b;

  // Pick R/G/B out of A, B(above_q), C, D by the colour of D.
  always_comb begin
    win_r = d_q;
    win_g = avg(above_q, c_q);
    win_b = a_q;
    unique case (s1_phase)
      PH_R: begin
        win_r = d_q;
        win_b = a_q;
        win_g = avg(above_q, c_q);
      end
      PH_B: begin
        win_r = a_q;
        win_b = d_q;
        win_g = avg(above_q, c_q);
      end
      PH_GR: begin
        win_r = c_q;
        win_b = above_q;
        win_g = avg(a_q, d_q);
      end
      PH_GB: begin
        win_r = above_q;
        win_b = c_q;
        win_g = avg(a_q, d_q);
      end
    endcase
  end

  logic [DATA_W-1:0] s2_r;
  logic [DATA_W-1:0] s2_g;
  logic [DATA_W-1:0] s2_b;
  logic              s2_valid;
  logic              s2_sof;
  logic              s2_eof;

  // Capture the computed pixel before the window registers move on.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s2_r     <= '0;
      s2_g     <= '0;
      s2_b     <= '0;
      s2_valid <= 1'b0;
      s2_sof   <= 1'b0;
      s2_eof   <= 1'b0;
    end else begin
      if (s1_valid) begin
        s2_r <= win_r;
        s2_g <= win_g;
        s2_b <= win_b;
      end
      s2_valid <= s1_valid;
      s2_sof   <= s1_sof;
      s2_eof   <= s1_eof;
    end
  end

  // ---------------------------------------------------------------------
  // Output register: colour holds while idle, markers pulse with oValid
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      oR     <= '0;
      oG     <= '0;
      oB     <= '0;
      oValid <= 1'b0;
      oSof   <= 1'b0;
      oEof   <= 1'b0;
    end else begin
      if (s2_valid) begin
        oR <= s2_r;
        oG <= s2_g;
        oB <= s2_b;
      end
      oValid <= s2_valid;
      oSof   <= s2_valid && s2_sof;
      oEof   <= s2_valid && s2_eof;
    end
  end

endmodule

// File: tb/tb_demosaic_window.sv
// Bench for demosaic_window: three instances (RGGB half-res, RGGB full-res,
// BGGR full-res) share one raw stream; a frame-image model predicts every
// output and its arrival cycle, and a per-cycle compare checks all of them.
module tb_demosaic_window;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int DW = 8;
  localparam int N  = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] idata = '0;
  logic          ivalid = 1'b0;
  logic          isof = 1'b0;

  logic [DW-1:0] o_r [N];
  logic [DW-1:0] o_g [N];
  logic [DW-1:0] o_b [N];
  logic          o_v [N];
  logic          o_s [N];
  logic          o_e [N];

  always #5 clk = ~clk;

  demosaic_window #(.WIDTH(W), .HEIGHT(H), .DATA_W(DW), .PATTERN(0), .MODE(0)) u_rggb_half (
    .clk(clk), .reset(reset), .iData(idata), .iValid(ivalid), .iSof(isof),
    .oR(o_r[0]), .oG(o_g[0]), .oB(o_b[0]), .oValid(o_v[0]), .oSof(o_s[0]), .oEof(o_e[0]));

  demosaic_window #(.WIDTH(W), .HEIGHT(H), .DATA_W(DW), .PATTERN(0), .MODE(1)) u_rggb_full (
    .clk(clk), .reset(reset), .iData(idata), .iValid(ivalid), .iSof(isof),
    .oR(o_r[1]), .oG(o_g[1]), .oB(o_b[1]), .oValid(o_v[1]), .oSof(o_s[1]), .oEof(o_e[1]));

  demosaic_window #(.WIDTH(W), .HEIGHT(H), .DATA_W(DW), .PATTERN(3), .MODE(1)) u_bggr_full (
    .clk(clk), .reset(reset), .iData(idata), .iValid(ivalid), .iSof(isof),
    .oR(o_r[2]), .oG(o_g[2]), .oB(o_b[2]), .oValid(o_v[2]), .oSof(o_s[2]), .oEof(o_e[2]));

  typedef enum {C_R, C_G, C_B} col_e;

  typedef struct packed {
    int          due;
    logic [23:0] rgb;
    logic        sof;
    logic        eof;
  } exp_t;

  exp_t        q [N][$];
  logic [23:0] last [N];
  logic [DW-1:0] img [H][W];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int mx    = 0;
  int my    = 0;
  int n_acc = 0;
  int tenth_cyc = 0;
  int n_out [N];
  int n_sof [N];
  int n_eof [N];
  int n_odd [N];
  int sof_cyc [N];

  localparam logic [23:0] UNIFORM_RGB = {8'd200, 8'd102, 8'd50};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  function automatic int mode_of(input int i);
    return (i == 0) ? 0 : 1;
  endfunction

  function automatic int pat_of(input int i);
    return (i == 2) ? 3 : 0;
  endfunction

  // CFA colour at (x,y) from the 2x2 tile named by the pattern.
  function automatic col_e colour_at(input int pat, input int x, input int y);
    col_e tile [4];
    case (pat)
      0:       tile = '{C_R, C_G, C_G, C_B};
      1:       tile = '{C_G, C_R, C_B, C_G};
      2:       tile = '{C_G, C_B, C_R, C_G};
      default: tile = '{C_B, C_G, C_G, C_R};
    endcase
    return tile[(y % 2) * 2 + (x % 2)];
  endfunction

  // Uniform mosaic: R=200, B=50, G=101 on red rows and 104 on blue rows.
  function automatic logic [DW-1:0] uniform_at(input int pat, input int x, input int y);
    col_e c;
    c = colour_at(pat, x, y);
    if (c == C_R) return 8'd200;
    if (c == C_B) return 8'd50;
    return (colour_at(pat, x ^ 1, y) == C_R) ? 8'd101 : 8'd104;
  endfunction

  function automatic exp_t predict(input int pat, input int x, input int y);
    exp_t e;
    int a, b, c, d, r, g, bl;
    a = img[y-1][x-1];
    b = img[y-1][x];
    c = img[y][x-1];
    d = img[y][x];
    case (colour_at(pat, x, y))
      C_R: begin r = d; bl = a; g = (b + c) / 2; end
      C_B: begin r = a; bl = d; g = (b + c) / 2; end
      default: begin
        g = (a + d) / 2;
        if (colour_at(pat, x ^ 1, y) == C_R) begin r = c; bl = b; end
        else begin r = b; bl = c; end
      end
    endcase
    e.due = cyc + 2;
    e.rgb = {8'(r), 8'(g), 8'(bl)};
    e.sof = (x == 1) && (y == 1);
    e.eof = (x == W - 1) && (y == H - 1);
    return e;
  endfunction

  task automatic model_accept(input logic s, input logic [DW-1:0] d);
    int cx, cy;
    bit emits;
    cx = s ? 0 : mx;
    cy = s ? 0 : my;
    img[cy][cx] = d;
    for (int i = 0; i < N; i++) begin
      if (mode_of(i) == 0) emits = (cx % 2 == 1) && (cy % 2 == 1);
      else                 emits = (cx >= 1) && (cy >= 1);
      if (emits) q[i].push_back(predict(pat_of(i), cx, cy));
    end
    mx = cx + 1;
    my = cy;
    if (mx == W) begin
      mx = 0;
      my = (cy + 1) % H;
    end
  endtask

  task automatic model_reset();
    mx = 0;
    my = 0;
    for (int i = 0; i < N; i++) begin
      q[i].delete();
      last[i] = '0;
    end
  endtask

  task automatic clear_stats();
    for (int i = 0; i < N; i++) begin
      n_out[i] = 0; n_sof[i] = 0; n_eof[i] = 0; n_odd[i] = 0; sof_cyc[i] = -1;
    end
    n_acc = 0;
    tenth_cyc = -1;
  endtask

  task automatic drive(input logic v, input logic s, input logic [DW-1:0] d);
    ivalid = v;
    isof   = s;
    idata  = d;
    @(posedge clk);
    cyc++;
    if (v) begin
      n_acc++;
      if (n_acc == 10) tenth_cyc = cyc;
      model_accept(s, d);
    end
    #1;
  endtask

  task automatic idle(input int n);
    // iSof without iValid must be ignored, so toggle it during gaps.
    for (int k = 0; k < n; k++) drive(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
  endtask

  task automatic do_reset(input int n);
    reset  = 1'b0;
    ivalid = 1'b0;
    isof   = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      cyc++;
      model_reset();
    end
    #1;
    reset = 1'b1;
  endtask

  // Send count samples in raster order; uniform=1 places values by colour.
  task automatic send_pixels(input int count, input bit first_sof, input int gap_pct,
                             input bit uniform, input int pat, input bit long_gap);
    for (int i = 0; i < count; i++) begin
      logic [DW-1:0] v;
      v = uniform ? uniform_at(pat, i % W, (i / W) % H) : 8'($urandom);
      while ($urandom_range(0, 99) < gap_pct) idle(1);
      if (long_gap && i == 2 * W + 4) idle(5);
      drive(1'b1, first_sof && (i == 0), v);
    end
  endtask

  // Per-cycle compare of every instance against the model queues.
  always @(negedge clk) begin
    if (cyc >= 1) begin
      for (int i = 0; i < N; i++) begin
        exp_t e;
        if (o_v[i] === 1'b1) begin
          n_out[i]++;
          if (o_s[i]) begin n_sof[i]++; sof_cyc[i] = cyc; end
          if (o_e[i]) n_eof[i]++;
          if ({o_r[i], o_g[i], o_b[i]} != UNIFORM_RGB) n_odd[i]++;
        end
        while (q[i].size() > 0 && q[i][0].due < cyc) begin
          e = q[i].pop_front();
          check($sformatf("inst%0d missed output due %0d", i, e.due), 32'd0, 32'd1);
        end
        if (q[i].size() > 0 && q[i][0].due == cyc) begin
          e = q[i].pop_front();
          check($sformatf("inst%0d valid", i), 32'(o_v[i]), 32'd1);
          check($sformatf("inst%0d rgb", i), 32'({o_r[i], o_g[i], o_b[i]}), 32'(e.rgb));
          check($sformatf("inst%0d sof/eof", i), 32'({o_s[i], o_e[i]}), 32'({e.sof, e.eof}));
          last[i] = e.rgb;
        end else begin
          check($sformatf("inst%0d idle valid", i), 32'(o_v[i]), 32'd0);
          check($sformatf("inst%0d idle hold", i), 32'({o_r[i], o_g[i], o_b[i]}), 32'(last[i]));
          check($sformatf("inst%0d idle sof/eof", i), 32'({o_s[i], o_e[i]}), 32'd0);
        end
      end
    end
  end

  initial begin
    model_reset();
    clear_stats();
    do_reset(3);

    // Uniform RGGB frame, no gaps: literal counts, values and latency.
    clear_stats();
    send_pixels(W * H, 1'b1, 0, 1'b1, 0, 1'b0);
    idle(4);
    check("half count",   32'(n_out[0]), 32'd8);
    check("half sof",     32'(n_sof[0]), 32'd1);
    check("half eof",     32'(n_eof[0]), 32'd1);
    check("half uniform", 32'(n_odd[0]), 32'd0);
    check("half latency", 32'(sof_cyc[0]), 32'(tenth_cyc + 2));
    check("full count",   32'(n_out[1]), 32'd21);
    check("full uniform", 32'(n_odd[1]), 32'd0);
    check("full eof",     32'(n_eof[1]), 32'd1);

    // Uniform BGGR frame seen by the BGGR instance.
    clear_stats();
    send_pixels(W * H, 1'b1, 0, 1'b1, 3, 1'b0);
    idle(4);
    check("bggr count",   32'(n_out[2]), 32'd21);
    check("bggr uniform", 32'(n_odd[2]), 32'd0);

    // Random data with 30% gaps and a 5-cycle hole in row 2.
    for (int f = 0; f < 3; f++) send_pixels(W * H, 1'b1, 30, 1'b0, 0, 1'b1);
    idle(4);

    // Reset at pixel (3,2), then a frame with no iSof.
    send_pixels(2 * W + 3, 1'b1, 0, 1'b0, 0, 1'b0);
    do_reset(1);
    for (int i = 0; i < N; i++) begin
      check($sformatf("inst%0d rgb after reset", i), 32'({o_r[i], o_g[i], o_b[i]}), 32'd0);
      check($sformatf("inst%0d valid after reset", i), 32'(o_v[i]), 32'd0);
    end
    clear_stats();
    send_pixels(W * H, 1'b0, 20, 1'b0, 0, 1'b0);
    idle(4);
    check("post-reset sof latency", 32'(sof_cyc[0]), 32'(tenth_cyc + 2));
    check("post-reset full sof",    32'(sof_cyc[1]), 32'(tenth_cyc + 2));
    check("post-reset eof",         32'(n_eof[0]), 32'd1);

    // iSof arriving at pixel (5,1) abandons the partial frame.
    clear_stats();
    send_pixels(W + 5, 1'b1, 0, 1'b0, 0, 1'b0);
    n_acc = 0;
    tenth_cyc = -1;
    send_pixels(W * H, 1'b1, 25, 1'b0, 0, 1'b0);
    idle(4);
    check("resync sof latency", 32'(sof_cyc[0]), 32'(tenth_cyc + 2));
    check("resync sof count",   32'(n_sof[0]), 32'd2);
    check("resync eof count",   32'(n_eof[0]), 32'd1);

    // Mixed random traffic, including random mid-frame resyncs.
    for (int f = 0; f < 4; f++) begin
      send_pixels($urandom_range(W, W * H), 1'b1, 30, 1'b0, 0, 1'b0);
    end
    idle(6);
    for (int i = 0; i < N; i++) begin
      check($sformatf("inst%0d queue drained", i), 32'(q[i].size()), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
